// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared types and constants for the HC-SR04 echo controller.
// Holds the controller state encoding, the 16-bit result/counter width,
// the microseconds-per-centimetre divisor and one restoring-divider step.
package hcsr04_pkg;

    localparam int RES_W = 16;

    // Round-trip microseconds per centimetre of distance.
    localparam logic [RES_W-1:0] CM_DIVISOR = 16'd58;

    // Result reported when no usable echo was seen.
    localparam logic [RES_W-1:0] RES_TIMEOUT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_CONVERT   = 3'd4,
        S_HOLDOFF   = 3'd5
    } state_t;

    // One restoring-division iteration: shift the next dividend bit into
    // the partial remainder, subtract the divisor when it fits and shift
    // the resulting quotient bit in. Returns {remainder, quotient}.
    function automatic logic [2*RES_W-1:0] div_step(input logic [RES_W-1:0] rem,
                                                    input logic [RES_W-1:0] quo);
        logic [RES_W:0] trial;
        trial = {rem, quo[RES_W-1]};
        if (trial >= {1'b0, CM_DIVISOR}) begin
            trial = trial - {1'b0, CM_DIVISOR};
            return {trial[RES_W-1:0], quo[RES_W-2:0], 1'b1};
        end
        return {trial[RES_W-1:0], quo[RES_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/hcsr04_sync.sv
// hcsr04_sync: two-flop synchronizer for the asynchronous echo input,
// followed by one history flop for single-cycle rising/falling edge pulses.
// Both edges see the same latency, so a width measured between them is exact.
module hcsr04_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchronizer chain plus delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;
    assign fall = ~sync & sync_d;

endmodule

// File: rtl/hcsr04_echo_ctrl.sv
// hcsr04_echo_ctrl: HC-SR04 ultrasonic ranger controller.
// Issues a trigger pulse, times the echo in microseconds and reports either
// the raw echo time or, with HCSR04_CM_CONV_EN defined, the distance in cm
// (echo_us / 58 via a 16-cycle restoring divider). Missing or over-long
// echoes report 16'hFFFF with a sticky timeout flag.
// Handshake: result_valid_o is a one-cycle pulse on the cycle result_o and
// timeout_o update; result_o then holds until the next pulse. There is no
// back-pressure, start_i is only honoured in IDLE.
module hcsr04_echo_ctrl
    import hcsr04_pkg::*;
#(
    parameter int US_DIV     = 100,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 38000,
    parameter int HOLDOFF_US = 60000
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             start_i,
    input  logic             continuous_i,
    input  logic             echo_i,
    output logic             trig_o,
    output logic             busy_o,
    output logic [RES_W-1:0] result_o,
    output logic             result_valid_o,
    output logic             timeout_o,
    output state_t           dbg_state
);

    localparam int               PRESC_W      = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(US_DIV - 1);
    localparam logic [RES_W-1:0] TRIG_LAST    = RES_W'(TRIG_US - 1);
    localparam logic [RES_W-1:0] TIMEOUT_LAST = RES_W'(TIMEOUT_US - 1);
    localparam logic [RES_W-1:0] HOLD_LAST    = RES_W'(HOLDOFF_US - 1);

    state_t             state;
    logic [PRESC_W-1:0] presc;
    logic [RES_W-1:0]   us_cnt;
    logic [RES_W-1:0]   us_next;
    logic               us_tick;
    logic               echo_rise;
    logic               echo_fall;

`ifdef HCSR04_CM_CONV_EN
    logic [RES_W-1:0]   div_q;
    logic [RES_W-1:0]   div_r;
    logic [RES_W-1:0]   div_q_nxt;
    logic [RES_W-1:0]   div_r_nxt;
    logic [3:0]         div_cnt;
`else
    logic [RES_W-1:0]   echo_us;
`endif

    hcsr04_sync u_sync (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .din   (echo_i),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    // Microsecond tick and the saturating count including this cycle's tick.
    always_comb begin
        us_tick = (presc == PRESC_LAST);
        us_next = us_cnt;
        if (us_tick && (us_cnt != RES_TIMEOUT)) begin
            us_next = us_cnt + RES_W'(1);
        end
    end

`ifdef HCSR04_CM_CONV_EN
    // Next restoring-divider iteration for the CONVERT state.
    always_comb begin
        {div_r_nxt, div_q_nxt} = div_step(div_r, div_q);
    end
`endif

    assign dbg_state = state;

    // Controller FSM with registered outputs; the prescaler and microsecond
    // counter restart from zero on every state change.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state          <= S_IDLE;
            trig_o         <= 1'b0;
            busy_o         <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            timeout_o      <= 1'b0;
            presc          <= '0;
            us_cnt         <= '0;
`ifdef HCSR04_CM_CONV_EN
            div_q          <= '0;
            div_r          <= '0;
            div_cnt        <= '0;
`else
            echo_us        <= '0;
`endif
        end else begin
            result_valid_o <= 1'b0;
            presc          <= us_tick ? '0 : presc + PRESC_W'(1);
            us_cnt         <= us_next;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state  <= S_TRIG;
                        trig_o <= 1'b1;
                        busy_o <= 1'b1;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end

                S_TRIG: begin
                    if (us_tick && (us_cnt == TRIG_LAST)) begin
                        state  <= S_WAIT_RISE;
                        trig_o <= 1'b0;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end

                S_WAIT_RISE: begin
                    // An edge wins over a timeout landing in the same cycle.
                    if (echo_rise) begin
                        state  <= S_MEASURE;
                        presc  <= '0;
                        us_cnt <= '0;
                    end else if (us_tick && (us_cnt == TIMEOUT_LAST)) begin
                        state          <= S_HOLDOFF;
                        result_o       <= RES_TIMEOUT;
                        timeout_o      <= 1'b1;
                        result_valid_o <= 1'b1;
                        presc          <= '0;
                        us_cnt         <= '0;
                    end
                end

                S_MEASURE: begin
                    if (echo_fall) begin
                        state  <= S_CONVERT;
                        presc  <= '0;
                        us_cnt <= '0;
`ifdef HCSR04_CM_CONV_EN
                        div_q   <= us_next;
                        div_r   <= '0;
                        div_cnt <= '0;
`else
                        echo_us <= us_next;
`endif
                    end else if (us_tick && (us_cnt == TIMEOUT_LAST)) begin
                        state          <= S_HOLDOFF;
                        result_o       <= RES_TIMEOUT;
                        timeout_o      <= 1'b1;
                        result_valid_o <= 1'b1;
                        presc          <= '0;
                        us_cnt         <= '0;
                    end
                end

                S_CONVERT: begin
`ifdef HCSR04_CM_CONV_EN
                    div_q   <= div_q_nxt;
                    div_r   <= div_r_nxt;
                    div_cnt <= div_cnt + 4'd1;
                    if (div_cnt == 4'd15) begin
                        state          <= S_HOLDOFF;
                        result_o       <= div_q_nxt;
                        timeout_o      <= 1'b0;
                        result_valid_o <= 1'b1;
                        presc          <= '0;
                        us_cnt         <= '0;
                    end
`else
                    state          <= S_HOLDOFF;
                    result_o       <= echo_us;
                    timeout_o      <= 1'b0;
                    result_valid_o <= 1'b1;
                    presc          <= '0;
                    us_cnt         <= '0;
`endif
                end

                S_HOLDOFF: begin
                    if (us_tick && (us_cnt == HOLD_LAST)) begin
                        presc  <= '0;
                        us_cnt <= '0;
                        if (continuous_i) begin
                            state  <= S_TRIG;
                            trig_o <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    trig_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_ctrl.sv
// tb_hcsr04_echo_ctrl: self-checking bench for hcsr04_echo_ctrl.
// Timing parameters are scaled down so every scenario fits a short run;
// expected values follow the macro HCSR04_CM_CONV_EN when it is defined.
module tb_hcsr04_echo_ctrl;
    import hcsr04_pkg::*;

    localparam int US_DIV     = 2;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 1500;
    localparam int HOLDOFF_US = 200;
    localparam int TRIG_CYC   = TRIG_US * US_DIV;
    localparam int TO_CYC     = TIMEOUT_US * US_DIV;
    localparam int HOLD_CYC   = HOLDOFF_US * US_DIV;
    localparam int NVEC       = 10;

    logic        ACLK         = 1'b0;
    logic        ARESETN      = 1'b0;
    logic        start_i      = 1'b0;
    logic        continuous_i = 1'b0;
    logic        echo_i       = 1'b0;
    logic        trig_o;
    logic        busy_o;
    logic [15:0] result_o;
    logic        result_valid_o;
    logic        timeout_o;
    state_t      dbg_state;

    int          n_cmp     = 0;
    int          n_fail    = 0;
    int          valid_cnt = 0;
    logic [15:0] held_res  = 16'h0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_exp;

    typedef struct {
        int          delay_us;
        int          width_us;
        bit          rises;
        logic [15:0] exp_res;
        bit          exp_to;
    } vec_t;

    vec_t vecs[NVEC];

    hcsr04_echo_ctrl #(
        .US_DIV     (US_DIV),
        .TRIG_US    (TRIG_US),
        .TIMEOUT_US (TIMEOUT_US),
        .HOLDOFF_US (HOLDOFF_US)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .start_i        (start_i),
        .continuous_i   (continuous_i),
        .echo_i         (echo_i),
        .trig_o         (trig_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .timeout_o      (timeout_o),
        .dbg_state      (dbg_state)
    );

    // Clock
    always #5 ACLK = ~ACLK;

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] conv(input int us);
`ifdef HCSR04_CM_CONV_EN
        return 16'(us / 58);
`else
        return 16'(us);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every valid pulse against the queued expectation
    // and flag any result change outside a valid pulse.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            held_res = 16'h0;
        end else if (result_valid_o) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got pulse with result %0h timeout %0b, expected no pulse",
                         result_o, timeout_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'(result_o), 32'(mon_exp[15:0]));
                check("timeout_flag", 32'(timeout_o), 32'(mon_exp[16]));
            end
            held_res = result_o;
        end else if (result_o !== held_res) begin
            n_cmp++;
            n_fail++;
            $display("FAIL result_stable: got %0h, expected %0h", result_o, held_res);
            held_res = result_o;
        end
    end

    task automatic pulse_start();
        @(negedge ACLK) start_i = 1'b1;
        @(negedge ACLK) start_i = 1'b0;
    endtask

    task automatic wait_trig_fall(output int cnt);
        cnt = 0;
        while (trig_o && cnt < 10 * TRIG_CYC) begin
            cnt++;
            @(negedge ACLK);
        end
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (busy_o && cnt < 20000) begin
            @(negedge ACLK);
            cnt++;
        end
        check("busy_drop", 32'(busy_o), 32'd0);
    endtask

    // One full single-shot measurement driven from a table record.
    task automatic run_meas(input vec_t v);
        int cnt;
        int v0;
        v0 = valid_cnt;
        exp_q.push_back({v.exp_to, v.exp_res});
        pulse_start();
        check("trig_rise", 32'(trig_o), 32'd1);
        check("busy_high", 32'(busy_o), 32'd1);
        wait_trig_fall(cnt);
        check("trig_width", 32'(cnt), 32'(TRIG_CYC));
        if (v.rises) begin
            repeat (v.delay_us * US_DIV) @(negedge ACLK);
            echo_i = 1'b1;
            repeat (v.width_us * US_DIV) @(negedge ACLK);
            echo_i = 1'b0;
        end else begin
            cnt = 0;
            while (!result_valid_o && cnt < 2 * TO_CYC) begin
                @(negedge ACLK);
                cnt++;
            end
            check("no_echo_timeout_delay", 32'(cnt), 32'(TO_CYC));
        end
        wait_idle();
        check("valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("timeout_sticky", 32'(timeout_o), 32'(v.exp_to));
    endtask

    initial begin
        int   cnt;
        int   v0;
        int   t;
        bit   prev;
        int   rises[$];
        vec_t good;

        vecs[0] = '{5, 580,  1'b1, conv(580),  1'b0};
        vecs[1] = '{3, 1,    1'b1, conv(1),    1'b0};
        vecs[2] = '{2, 57,   1'b1, conv(57),   1'b0};
        vecs[3] = '{2, 58,   1'b1, conv(58),   1'b0};
        vecs[4] = '{1, 1499, 1'b1, conv(1499), 1'b0};
        vecs[5] = '{1, 1500, 1'b1, conv(1500), 1'b0};
        vecs[6] = '{1, 1501, 1'b1, 16'hFFFF,   1'b1};
        vecs[7] = '{0, 0,    1'b0, 16'hFFFF,   1'b1};
        vecs[8] = '{4, 1700, 1'b1, 16'hFFFF,   1'b1};
        vecs[9] = '{4, 1160, 1'b1, conv(1160), 1'b0};

        // Reset state, both while held and right after release.
        repeat (3) @(negedge ACLK);
        check("rst_trig", 32'(trig_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_valid", 32'(result_valid_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("idle_state", 32'(dbg_state), 32'(S_IDLE));
        check("idle_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_meas(vecs[i]);
        end

        // Continuous mode with no echo: trigger spacing is trigger + timeout
        // + holdoff, and a start pulse while busy must not disturb it.
        continuous_i = 1'b1;
        repeat (3) exp_q.push_back({1'b1, 16'hFFFF});
        v0   = valid_cnt;
        prev = trig_o;
        t    = 0;
        while (t < 20000 && !(rises.size() == 3 && !busy_o)) begin
            @(negedge ACLK);
            if (trig_o && !prev) begin
                rises.push_back(t);
                if (rises.size() == 3) continuous_i = 1'b0;
            end
            prev    = trig_o;
            start_i = (t == 0) || (t == 200);
            t++;
        end
        start_i = 1'b0;
        check("cont_rise_count", 32'(rises.size()), 32'd3);
        if (rises.size() == 3) begin
            check("cont_spacing_01", 32'(rises[1] - rises[0]), 32'(TRIG_CYC + TO_CYC + HOLD_CYC));
            check("cont_spacing_12", 32'(rises[2] - rises[1]), 32'(TRIG_CYC + TO_CYC + HOLD_CYC));
            check("cont_min_holdoff", 32'((rises[1] - rises[0]) >= HOLD_CYC), 32'd1);
        end
        check("cont_valid_pulses", 32'(valid_cnt - v0), 32'd3);
        check("cont_idle", 32'(busy_o), 32'd0);

        // Reset in the middle of MEASURE discards the partial result.
        v0 = valid_cnt;
        pulse_start();
        wait_trig_fall(cnt);
        repeat (3 * US_DIV) @(negedge ACLK);
        echo_i = 1'b1;
        repeat (300 * US_DIV) @(negedge ACLK);
        check("mid_state_measure", 32'(dbg_state), 32'(S_MEASURE));
        ARESETN = 1'b0;
        #1;
        check("mid_rst_trig", 32'(trig_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_result", 32'(result_o), 32'd0);
        check("mid_rst_valid", 32'(result_valid_o), 32'd0);
        repeat (3) @(negedge ACLK);
        echo_i = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("mid_rst_no_valid", 32'(valid_cnt - v0), 32'd0);

        good = '{5, 580, 1'b1, conv(580), 1'b0};
        run_meas(good);

        // Reset while the trigger is high drops it immediately.
        pulse_start();
        repeat (5) @(negedge ACLK);
        check("trig_before_rst", 32'(trig_o), 32'd1);
        ARESETN = 1'b0;
        #1;
        check("trig_rst_trig", 32'(trig_o), 32'd0);
        check("trig_rst_result", 32'(result_o), 32'd0);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        good = '{2, 1160, 1'b1, conv(1160), 1'b0};
        run_meas(good);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
